keypad_scan_ctrl: RTL



---
 rtl/keypad_scan_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one column driven low per sample period, rows synchronized,
// one shared debounce counter; accepted keys are presented on a valid/ready interface.
module keypad_scan_ctrl #(
  parameter int CLK_FREQ         = 100_000_000,
  parameter int SAMPLE_US        = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam int SAMPLE_CYCLES = (CLK_FREQ / 1_000_000) * SAMPLE_US;
  localparam int TW = $clog2(SAMPLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SAMPLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    col_q, col_d, cand_row_q, cand_row_d;
  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    col_out_q, col_out_d, key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d, overflow_q, overflow_d;
  logic          tick, idle, accept;
  logic [1:0]    active_row;

  // Lowest-index row pulled low wins when several rows are active.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign idle       = (sync2_q == 4'b1111);
  assign active_row = lowest_low(sync2_q);
  assign cnt_inc    = cnt_q + CNT_ONE;

  // Next-state logic: scan/debounce FSM, handshake and overflow tracking
  always_comb begin
    sync1_d     = row_in;
    sync2_d     = sync1_q;
    tick_cnt_d  = tick ? {TW{1'b0}} : tick_cnt_q + TW'(1);
    col_out_d   = ~(4'b0001 << col_q);
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = key_valid_q & ~key_ready;
    overflow_d  = overflow_q & ~ovf_clr;
    accept      = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (idle) begin
            col_d = col_q + 2'd1;
          end else begin
            cand_row_d = active_row;
            cnt_d      = CNT_ONE;
            state_d    = DEBOUNCE;
            accept     = (CNT_ONE == CNT_DONE);
          end
        end
        DEBOUNCE: begin
          if (idle) begin
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end else begin
            if (active_row == cand_row_q) begin
              cnt_d = cnt_inc;
            end else begin
              cand_row_d = active_row;
              cnt_d      = CNT_ONE;
            end
            accept = (cnt_d == CNT_DONE);
          end
        end
        HELD: begin
          cnt_d = idle ? cnt_inc : {CW{1'b0}};
          if (idle && (cnt_inc == CNT_DONE)) begin
            key_held_d = 1'b0;
            col_d      = col_q + 2'd1;
            state_d    = SCAN;
          end else begin
            key_held_d = 1'b1;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
      if (accept) begin
        state_d    = HELD;
        cnt_d      = {CW{1'b0}};
        key_held_d = 1'b1;
        // A pending key that is not being consumed this cycle keeps priority over the new one.
        if (!key_valid_q || key_ready) begin
          key_code_d  = {cand_row_d, col_q};
          key_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        accept = 1'b0;
      end
    end else begin
      accept = 1'b0;
    end
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      tick_cnt_q  <= {TW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      col_q       <= 2'd0;
      cand_row_q  <= 2'd0;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      col_out_q   <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      col_out_q   <= col_out_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overflow_q  <= overflow_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

endmodule
